// File: rtl/alu_pkg.sv
// Shared definitions for the ALU self-test sweeper.
//   ALU_CTRL_W      : width of the {zx,nx,zy,ny,f,no} control word
//   ALU_*           : named control codes of the Hack ALU
//   sweep_state_e   : sequencer state encoding
package alu_pkg;

  localparam int ALU_CTRL_W = 6;

  localparam logic [ALU_CTRL_W-1:0] ALU_ZERO   = 6'b101010;
  localparam logic [ALU_CTRL_W-1:0] ALU_ONE    = 6'b111111;
  localparam logic [ALU_CTRL_W-1:0] ALU_NEG1   = 6'b111010;
  localparam logic [ALU_CTRL_W-1:0] ALU_X      = 6'b001100;
  localparam logic [ALU_CTRL_W-1:0] ALU_Y      = 6'b110000;
  localparam logic [ALU_CTRL_W-1:0] ALU_XPLUSY = 6'b000010;
  localparam logic [ALU_CTRL_W-1:0] ALU_XANDY  = 6'b000000;
  localparam logic [ALU_CTRL_W-1:0] ALU_XORY   = 6'b010101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/alu_signature.sv
// Result signature and flag-error counter for the ALU sweeper.
//   clk, rst   : clock, async active-high reset
//   clr        : zero signature and error count (start of a sweep)
//   cap_en     : fold one ALU capture in
//   result/zr/ng : ALU outputs being captured
//   signature  : rotate-left-then-XOR accumulation of results
//   err_count  : captures whose zr/ng disagree with the result
module alu_signature
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cap_en,
  input  logic [WIDTH-1:0] result,
  input  logic             zr,
  input  logic             ng,
  output logic [WIDTH-1:0] signature,
  output logic [6:0]       err_count
);

  logic [WIDTH-1:0] sig_q, sig_d;
  logic [6:0]       err_q, err_d;
  logic             flag_bad;

  always_comb begin
    sig_d    = sig_q;
    err_d    = err_q;
    // Both flag faults on one code still count once.
    flag_bad = (zr != (result == '0)) || (ng != result[WIDTH-1]);
    if (clr) begin
      sig_d = '0;
      err_d = '0;
    end else if (cap_en) begin
      sig_d = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ result;
      // At most 64 captures per sweep, so 7 bits never wrap.
      if (flag_bad) err_d = err_q + 7'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
      err_q <= '0;
    end else begin
      sig_q <= sig_d;
      err_q <= err_d;
    end
  end

  assign signature = sig_q;
  assign err_count = err_q;

endmodule

// File: rtl/alu_sweeper.sv
// Self-test sequencer for a Hack-style ALU. Latches an operand pair on
// start, walks control codes 0..63, captures result/zr/ng per code into a
// signature and a flag-error count, then pulses done.
//   clk, rst          : clock, async active-high reset
//   start, op_x, op_y : sweep request and operands (sampled in IDLE)
//   alu_x, alu_y      : latched operands to the ALU
//   zx..no            : ALU control = code[5:0] MSB->LSB
//   alu_result/zr/ng  : ALU outputs
//   busy, done, code  : sweep status
//   signature, err_count : sweep results, held until the next start
module alu_sweeper
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      op_x,
  input  logic [WIDTH-1:0]      op_y,
  output logic [WIDTH-1:0]      alu_x,
  output logic [WIDTH-1:0]      alu_y,
  output logic                  zx,
  output logic                  nx,
  output logic                  zy,
  output logic                  ny,
  output logic                  f,
  output logic                  no,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zr,
  input  logic                  alu_ng,
  output logic                  busy,
  output logic                  done,
  output logic [ALU_CTRL_W-1:0] code,
  output logic [WIDTH-1:0]      signature,
  output logic [6:0]            err_count
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  sweep_state_e          state_q, state_d;
  logic [ALU_CTRL_W-1:0] code_q, code_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [WIDTH-1:0]      x_q, x_d, y_q, y_d;
  logic                  sig_clr, sig_cap;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    sig_clr = 1'b0;
    sig_cap = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = op_x;
          y_d     = op_y;
          code_d  = '0;
          cnt_d   = '0;
          sig_clr = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // Counter parks at SETTLE; DRIVE therefore lasts SETTLE+1 cycles.
        if (cnt_q == SETTLE_C) state_d = ST_CAPTURE;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      ST_CAPTURE: begin
        sig_cap = 1'b1;
        if (code_q == '1) begin
          state_d = ST_DONE;
        end else begin
          code_d  = code_q + 1'b1;
          cnt_d   = '0;
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  alu_signature #(.WIDTH(WIDTH)) u_sig (
    .clk       (clk),
    .rst       (rst),
    .clr       (sig_clr),
    .cap_en    (sig_cap),
    .result    (alu_result),
    .zr        (alu_zr),
    .ng        (alu_ng),
    .signature (signature),
    .err_count (err_count)
  );

  assign alu_x = x_q;
  assign alu_y = y_q;
  assign {zx, nx, zy, ny, f, no} = code_q;
  assign code  = code_q;
  assign busy  = (state_q == ST_DRIVE) || (state_q == ST_CAPTURE);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_sweeper.sv
// Two sweepers (SETTLE=0 and SETTLE=2) share stimulus, each driving its own
// behavioural Hack ALU. A model keyed on start/rst pushes the expected sweep
// into a per-DUT scoreboard; a negedge monitor checks every cycle and pops
// the scoreboard on each done pulse.
module tb_alu_sweeper;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_x = '0, op_y = '0;
  logic         zr_fault = 1'b0;
  logic         b2b = 1'b0;

  always #5 clk = ~clk;

  logic [W-1:0] ax[2], ay[2], res[2], sig[2];
  logic         zx[2], nx[2], zy[2], ny[2], f[2], no[2], zr[2], ng[2];
  logic         busy[2], done[2];
  logic [5:0]   code[2];
  logic [6:0]   errc[2];

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [5:0] c);
    logic [W-1:0] a, b, o;
    a = c[5] ? '0 : x;
    if (c[4]) a = ~a;
    b = c[3] ? '0 : y;
    if (c[2]) b = ~b;
    o = c[1] ? a + b : a & b;
    if (c[0]) o = ~o;
    return o;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_alu
    assign res[g] = alu_f(ax[g], ay[g], {zx[g], nx[g], zy[g], ny[g], f[g], no[g]});
    assign zr[g]  = zr_fault ? 1'b0 : (res[g] == '0);
    assign ng[g]  = res[g][W-1];
  end

  alu_sweeper #(.WIDTH(W), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .op_x(op_x), .op_y(op_y),
    .alu_x(ax[0]), .alu_y(ay[0]), .zx(zx[0]), .nx(nx[0]), .zy(zy[0]), .ny(ny[0]),
    .f(f[0]), .no(no[0]), .alu_result(res[0]), .alu_zr(zr[0]), .alu_ng(ng[0]),
    .busy(busy[0]), .done(done[0]), .code(code[0]), .signature(sig[0]),
    .err_count(errc[0]));

  alu_sweeper #(.WIDTH(W), .SETTLE(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .op_x(op_x), .op_y(op_y),
    .alu_x(ax[1]), .alu_y(ay[1]), .zx(zx[1]), .nx(nx[1]), .zy(zy[1]), .ny(ny[1]),
    .f(f[1]), .no(no[1]), .alu_result(res[1]), .alu_zr(zr[1]), .alu_ng(ng[1]),
    .busy(busy[1]), .done(done[1]), .code(code[1]), .signature(sig[1]),
    .err_count(errc[1]));

  typedef struct {
    logic [W-1:0] sig;
    int           err;
    longint       done_edge;
  } exp_t;

  exp_t         sb0[$], sb1[$];
  longint       edge_cnt = 0;
  int           rem[2] = '{0, 0};
  logic [W-1:0] lat_x[2], lat_y[2];
  logic [W-1:0] hs[2][65];
  int           he[2][65];
  longint       last_done[2] = '{-1, -1};
  int           errors = 0, checks = 0;

  // cycles per code = SETTLE + 2
  function automatic int per_code(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference model: acceptance, sweep length and expected results.
  always @(posedge clk) begin
    exp_t         e;
    logic [W-1:0] s, r;
    int           ec;
    edge_cnt++;
    for (int i = 0; i < 2; i++) begin
      if (rst) rem[i] = 0;
      else if (rem[i] > 0) rem[i]--;
      else if (start) begin
        s = '0; ec = 0;
        hs[i][0] = '0; he[i][0] = 0;
        for (int c = 0; c < 64; c++) begin
          r = alu_f(op_x, op_y, 6'(c));
          s = ((s << 1) | (s >> (W - 1))) ^ r;
          if (zr_fault && r == '0) ec++;
          hs[i][c+1] = s;
          he[i][c+1] = ec;
        end
        lat_x[i] = op_x;
        lat_y[i] = op_y;
        rem[i] = 64 * per_code(i) + 1;
        e.sig = s;
        e.err = ec;
        e.done_edge = edge_cnt + 64 * per_code(i);
        if (i == 0) sb0.push_back(e);
        else        sb1.push_back(e);
      end
    end
    if (rst) begin
      sb0.delete();
      sb1.delete();
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t       e;
    int         k, cd;
    logic [5:0] cv;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        cv = {zx[i], nx[i], zy[i], ny[i], f[i], no[i]};
        chk($sformatf("d%0d busy", i), busy[i], rem[i] > 1);
        chk($sformatf("d%0d done", i), done[i], rem[i] == 1);
        if (rem[i] > 1) begin
          k  = 64 * per_code(i) + 1 - rem[i];
          cd = k / per_code(i);
          chk($sformatf("d%0d code", i), code[i], cd);
          chk($sformatf("d%0d ctl", i), cv, cd);
          chk($sformatf("d%0d sig@%0d", i, k), sig[i], hs[i][cd]);
          chk($sformatf("d%0d err@%0d", i, k), errc[i], he[i][cd]);
          chk($sformatf("d%0d alu_x", i), ax[i], lat_x[i]);
          chk($sformatf("d%0d alu_y", i), ay[i], lat_y[i]);
        end
        if (done[i]) begin
          if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
            chk($sformatf("d%0d unexpected done", i), 1, 0);
          end else begin
            e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
            chk($sformatf("d%0d final sig", i), sig[i], e.sig);
            chk($sformatf("d%0d final err", i), errc[i], e.err);
            chk($sformatf("d%0d done edge", i), edge_cnt, e.done_edge);
          end
          if (b2b && last_done[i] >= 0)
            chk($sformatf("d%0d b2b gap", i), edge_cnt - last_done[i], 64 * per_code(i) + 2);
          last_done[i] = edge_cnt;
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s d%0d busy", tag, i), busy[i], 0);
      chk($sformatf("%s d%0d done", tag, i), done[i], 0);
      chk($sformatf("%s d%0d code", tag, i), code[i], 0);
      chk($sformatf("%s d%0d ctl", tag, i), {zx[i], nx[i], zy[i], ny[i], f[i], no[i]}, 0);
      chk($sformatf("%s d%0d sig", tag, i), sig[i], 0);
      chk($sformatf("%s d%0d err", tag, i), errc[i], 0);
      chk($sformatf("%s d%0d alu_x", tag, i), ax[i], 0);
      chk($sformatf("%s d%0d alu_y", tag, i), ay[i], 0);
    end
  endtask

  task automatic pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((rem[0] != 0 || rem[1] != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("idle timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic wait_code(input int c);
    int n;
    n = 0;
    while (!(busy[0] && code[0] == 6'(c)) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk($sformatf("wait code %0d timeout", c), 1, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;

    // golden sweep
    op_x = 16'd2; op_y = 16'd2;
    pulse(); wait_idle();

    // random operands
    repeat (3) begin
      op_x = W'($urandom); op_y = W'($urandom);
      pulse(); wait_idle();
    end

    // forced zr=0 with zero operands, then the same operands fault-free
    zr_fault = 1'b1; op_x = '0; op_y = '0;
    pulse(); wait_idle();
    zr_fault = 1'b0;
    pulse(); wait_idle();

    // start while busy must not disturb the running sweep
    op_x = 16'h1234; op_y = 16'hABCD;
    pulse();
    wait_code(10);
    op_x = 16'h5555; op_y = 16'h0F0F;
    pulse(); wait_idle();

    // reset mid-sweep
    op_x = W'($urandom); op_y = W'($urandom);
    pulse();
    wait_code(30);
    #1 rst = 1'b1;
    #1 check_reset("mid");
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    op_x = 16'h8000; op_y = 16'h7FFF;
    pulse(); wait_idle();

    // back-to-back sweeps with start held
    b2b = 1'b1;
    last_done[0] = -1; last_done[1] = -1;
    op_x = 16'hFFFF; op_y = 16'h0001;
    @(negedge clk) start = 1'b1;
    repeat (560) @(negedge clk);
    start = 1'b0;
    wait_idle();
    b2b = 1'b0;

    chk("d0 scoreboard drained", sb0.size(), 0);
    chk("d1 scoreboard drained", sb1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
